// File: rtl/fp_mul_pipe_if.sv
// Operand/result handshake bundle for fp_mul_pipe: valid/ready on both sides,
// word layout {sign, exponent, mantissa}.
interface fp_mul_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 7
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_p;
    logic         out_ovf;
    logic         out_unf;
    logic         out_inv;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_p, out_ovf, out_unf, out_inv
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_p, out_ovf, out_unf, out_inv
    );
endinterface

// File: rtl/fp_mul_pipe.sv
// 3-stage pipelined floating-point multiplier (bfloat16 by default), global-stall handshake.
// Define FP_MUL_RNE_EN for round-to-nearest-even; otherwise results are truncated.
module fp_mul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    fp_mul_pipe_if.slave bus
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int EW   = EXP_W + 2;
    localparam int PW   = 2 * (MAN_W + 1);
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam logic [EXP_W-1:0]     EXP_ONES  = '1;
    localparam logic signed [EW-1:0] BIAS_S    = EW'(BIAS);
    localparam logic signed [EW-1:0] EXP_MAX_S = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] ZERO_S    = '0;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    // Stage 1: classified operands and biased exponent sum
    logic                 s1_valid_q, s1_valid_d;
    logic                 s1_sign_q, s1_sign_d;
    logic                 s1_nan_q, s1_nan_d, s1_inf_q, s1_inf_d, s1_zero_q, s1_zero_d, s1_inv_q, s1_inv_d;
    logic signed [EW-1:0] s1_exp_q, s1_exp_d;
    logic [MAN_W:0]       s1_ma_q, s1_ma_d, s1_mb_q, s1_mb_d;
    // Stage 2: full significand product
    logic                 s2_valid_q, s2_valid_d;
    logic                 s2_sign_q, s2_sign_d;
    logic                 s2_nan_q, s2_nan_d, s2_inf_q, s2_inf_d, s2_zero_q, s2_zero_d, s2_inv_q, s2_inv_d;
    logic signed [EW-1:0] s2_exp_q, s2_exp_d;
    logic [PW-1:0]        s2_prod_q, s2_prod_d;
    // Stage 3: packed result
    logic                 out_valid_q, out_valid_d;
    logic [W-1:0]         out_p_q, out_p_d;
    logic                 out_ovf_q, out_ovf_d, out_unf_q, out_unf_d, out_inv_q, out_inv_d;

    logic                 adv;
    logic                 sa, sb, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, inf_x_zero;
    logic [EXP_W-1:0]     ea, eb;
    logic [MAN_W-1:0]     ma, mb;
    logic                 prod_msb, rnd_inc, rnd_carry;
    logic [PW-1:0]        prod_n;
    logic [MAN_W-1:0]     man_t;
    logic [MAN_W:0]       man_r;
    logic signed [EW-1:0] exp_n, exp_r;
`ifndef FP_MUL_RNE_EN
    logic                 rnd_bits_unused;
`endif

    assign adv          = !out_valid_q || bus.out_ready;
    assign bus.in_ready = adv;
    assign bus.out_valid = out_valid_q;
    assign bus.out_p     = out_p_q;
    assign bus.out_ovf   = out_ovf_q;
    assign bus.out_unf   = out_unf_q;
    assign bus.out_inv   = out_inv_q;

    always_comb begin
        s1_valid_d = s1_valid_q; s1_sign_d = s1_sign_q; s1_nan_d = s1_nan_q; s1_inf_d = s1_inf_q;
        s1_zero_d = s1_zero_q; s1_inv_d = s1_inv_q; s1_exp_d = s1_exp_q; s1_ma_d = s1_ma_q; s1_mb_d = s1_mb_q;
        s2_valid_d = s2_valid_q; s2_sign_d = s2_sign_q; s2_nan_d = s2_nan_q; s2_inf_d = s2_inf_q;
        s2_zero_d = s2_zero_q; s2_inv_d = s2_inv_q; s2_exp_d = s2_exp_q; s2_prod_d = s2_prod_q;
        out_valid_d = out_valid_q; out_p_d = out_p_q;
        out_ovf_d = out_ovf_q; out_unf_d = out_unf_q; out_inv_d = out_inv_q;

        sa = bus.in_a[W-1]; ea = bus.in_a[W-2 -: EXP_W]; ma = bus.in_a[MAN_W-1:0];
        sb = bus.in_b[W-1]; eb = bus.in_b[W-2 -: EXP_W]; mb = bus.in_b[MAN_W-1:0];
        a_nan  = (ea == EXP_ONES) && (ma != '0);
        b_nan  = (eb == EXP_ONES) && (mb != '0);
        a_inf  = (ea == EXP_ONES) && (ma == '0);
        b_inf  = (eb == EXP_ONES) && (mb == '0);
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        inf_x_zero = (a_inf && b_zero) || (b_inf && a_zero);

        // Normalise so the leading one sits at PW-1; guard lands at bit MAN_W.
        prod_msb = s2_prod_q[PW-1];
        prod_n   = prod_msb ? s2_prod_q : (s2_prod_q << 1);
        man_t    = prod_n[PW-2 -: MAN_W];
        exp_n    = s2_exp_q + $signed({{(EW-1){1'b0}}, prod_msb});
`ifdef FP_MUL_RNE_EN
        rnd_inc  = prod_n[MAN_W] && ((|prod_n[MAN_W-1:0]) || man_t[0]);
`else
        rnd_inc  = 1'b0;
        rnd_bits_unused = |prod_n[MAN_W:0];
`endif
        man_r     = {1'b0, man_t} + {{MAN_W{1'b0}}, rnd_inc};
        rnd_carry = man_r[MAN_W];
        exp_r     = exp_n + $signed({{(EW-1){1'b0}}, rnd_carry});

        if (adv) begin
            s1_valid_d = bus.in_valid;
            s1_sign_d  = sa ^ sb;
            s1_nan_d   = a_nan || b_nan || inf_x_zero;
            s1_inv_d   = inf_x_zero;
            s1_inf_d   = a_inf || b_inf;
            s1_zero_d  = a_zero || b_zero;
            s1_exp_d   = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_S;
            s1_ma_d    = {1'b1, ma};
            s1_mb_d    = {1'b1, mb};

            s2_valid_d = s1_valid_q; s2_sign_d = s1_sign_q; s2_nan_d = s1_nan_q;
            s2_inf_d   = s1_inf_q;   s2_zero_d = s1_zero_q; s2_inv_d = s1_inv_q;
            s2_exp_d   = s1_exp_q;
            s2_prod_d  = PW'(s1_ma_q) * PW'(s1_mb_q);

            out_valid_d = s2_valid_q;
            out_ovf_d   = 1'b0;
            out_unf_d   = 1'b0;
            out_inv_d   = 1'b0;
            if (s2_nan_q) begin
                out_p_d   = QNAN;
                out_inv_d = s2_inv_q;
            end else if (s2_inf_q) begin
                out_p_d = {s2_sign_q, EXP_ONES, {MAN_W{1'b0}}};
            end else if (s2_zero_q) begin
                out_p_d = {s2_sign_q, {(W-1){1'b0}}};
            end else if (exp_r >= EXP_MAX_S) begin
                out_p_d   = {s2_sign_q, EXP_ONES, {MAN_W{1'b0}}};
                out_ovf_d = 1'b1;
            end else if (exp_r <= ZERO_S) begin
                out_p_d   = {s2_sign_q, {(W-1){1'b0}}};
                out_unf_d = 1'b1;
            end else begin
                out_p_d = {s2_sign_q, exp_r[EXP_W-1:0], man_r[MAN_W-1:0]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0; s1_sign_q <= 1'b0; s1_nan_q <= 1'b0; s1_inf_q <= 1'b0;
            s1_zero_q <= 1'b0; s1_inv_q <= 1'b0; s1_exp_q <= '0; s1_ma_q <= '0; s1_mb_q <= '0;
            s2_valid_q <= 1'b0; s2_sign_q <= 1'b0; s2_nan_q <= 1'b0; s2_inf_q <= 1'b0;
            s2_zero_q <= 1'b0; s2_inv_q <= 1'b0; s2_exp_q <= '0; s2_prod_q <= '0;
            out_valid_q <= 1'b0; out_p_q <= '0;
            out_ovf_q <= 1'b0; out_unf_q <= 1'b0; out_inv_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d; s1_sign_q <= s1_sign_d; s1_nan_q <= s1_nan_d; s1_inf_q <= s1_inf_d;
            s1_zero_q <= s1_zero_d; s1_inv_q <= s1_inv_d; s1_exp_q <= s1_exp_d; s1_ma_q <= s1_ma_d; s1_mb_q <= s1_mb_d;
            s2_valid_q <= s2_valid_d; s2_sign_q <= s2_sign_d; s2_nan_q <= s2_nan_d; s2_inf_q <= s2_inf_d;
            s2_zero_q <= s2_zero_d; s2_inv_q <= s2_inv_d; s2_exp_q <= s2_exp_d; s2_prod_q <= s2_prod_d;
            out_valid_q <= out_valid_d; out_p_q <= out_p_d;
            out_ovf_q <= out_ovf_d; out_unf_q <= out_unf_d; out_inv_q <= out_inv_d;
        end
    end
endmodule
